// File: rtl/mult_digit_shifter.sv
// Operand shifter for the shift-and-add multiplier: emits one radix-2^RADIX_BITS digit per handshake, LSD first.
// Optional MULT_DIGIT_EARLY_TERM_EN: end the sequence once all remaining digits are zero.
module mult_digit_shifter #(
  parameter int unsigned DW         = 16,
  parameter int unsigned RADIX_BITS = 1,
  localparam int unsigned NDIG      = (DW + RADIX_BITS - 1) / RADIX_BITS,
  localparam int unsigned CW        = ($clog2(NDIG) > 0) ? $clog2(NDIG) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DW-1:0]         i_data,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [RADIX_BITS-1:0] o_digit,
  output logic [CW-1:0]         o_idx,
  output logic                  o_last,
  output logic                  o_done
);

  localparam int unsigned SW = NDIG * RADIX_BITS;
  localparam logic [CW-1:0] LAST_IDX = CW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] shift_reg, shift_nx, rest_c;
  logic [CW-1:0] count, count_nx;
  logic          busy_q, valid_q, done_q, last_q, last_nx;
`ifdef MULT_DIGIT_EARLY_TERM_EN
  logic          nx_rest_zero_c;
`endif

  // Operand with the current digit dropped, and the zero-remainder test for early termination
  generate
    if (NDIG == 1) begin : g_single
      assign rest_c = '0;
`ifdef MULT_DIGIT_EARLY_TERM_EN
      assign nx_rest_zero_c = 1'b1;
`endif
    end else begin : g_multi
      assign rest_c = {{RADIX_BITS{1'b0}}, shift_reg[SW-1:RADIX_BITS]};
`ifdef MULT_DIGIT_EARLY_TERM_EN
      assign nx_rest_zero_c = (shift_nx[SW-1:RADIX_BITS] == '0);
`endif
    end
  endgenerate

  // Next-state and datapath update
  always_comb begin
    state_nx = state;
    shift_nx = shift_reg;
    count_nx = count;
    case (state)
      IDLE: begin
        if (i_start) begin
          shift_nx = SW'(i_data);
          count_nx = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (i_ready) begin
          shift_nx = rest_c;
          if (last_q) begin
            count_nx = '0;
            state_nx = DONE;
          end else begin
            count_nx = count + CW'(1);
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Last-digit flag for the digit presented next cycle
  always_comb begin
    last_nx = 1'b0;
    if (state_nx == SHIFT) begin
      last_nx = (count_nx == LAST_IDX);
`ifdef MULT_DIGIT_EARLY_TERM_EN
      if (nx_rest_zero_c) last_nx = 1'b1;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      shift_reg <= shift_nx;
      count     <= count_nx;
      busy_q    <= (state_nx != IDLE);
      valid_q   <= (state_nx == SHIFT);
      done_q    <= (state_nx == DONE);
      last_q    <= last_nx;
    end
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_done  = done_q;
  assign o_last  = last_q;
  assign o_idx   = count;
  assign o_digit = shift_reg[RADIX_BITS-1:0];

endmodule

// File: doc/mult_digit_shifter.md
Name: mult_digit_shifter

Overview:
Parametrised operand shifter for the sequential shift-and-add multiplier datapath. It loads a multiplier operand and presents it to the accumulator one radix-2^RADIX_BITS digit per handshake, least significant digit first. Each digit carries an index, a last flag and a valid/ready handshake, and a done pulse follows the last digit. It generalises the single-bit LSB shifter to any width and radix and adds backpressure and sequencing control.

Parameters:
DW, 16, operand width in bits (>=2)
RADIX_BITS, 1, bits per digit emitted per handshake (1..DW)
NDIG, derived = ceil(DW/RADIX_BITS), digits per operand; not user-set
CW, derived = $clog2(NDIG)>0 ? $clog2(NDIG) : 1, width of o_idx

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-low
i_start  in  1  load request; accepted only when o_busy=0
i_data  in  DW  operand, sampled on accepted i_start
i_ready  in  1  consumer accepts current digit when o_valid=1
o_busy  out  1  high from the cycle after an accepted start until the cycle after the o_done pulse
o_valid  out  1  o_digit/o_idx/o_last valid
o_digit  out  RADIX_BITS  current digit = shift_reg[RADIX_BITS-1:0]
o_idx  out  CW  index of current digit, 0..NDIG-1
o_last  out  1  current digit is the final one
o_done  out  1  one-cycle pulse after the last digit is accepted

Behaviour:
- Reset (async, i_rst=0): state=IDLE, shift_reg=0, count=0. All outputs 0. Reset mid-operation aborts: no o_done, no further digits.
- Internal shift_reg width is NDIG*RADIX_BITS. On load, i_data is zero-extended at the MSB end.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - o_busy=0, o_valid=0.
  - i_start=1 loads shift_reg, sets count=0 and moves to SHIFT.
  - From the next cycle: o_valid=1, o_idx=0, o_busy=1. Latency from start to first valid digit is 1 cycle.
- SHIFT:
  - o_valid=1, o_busy=1, o_idx=count.
  - Handshake = o_valid & i_ready. On handshake: shift_reg >>= RADIX_BITS (zero fill) and count++.
  - No handshake: all outputs and internal state hold, for any number of cycles.
  - o_last = (count==NDIG-1). Handshake while o_last=1 moves to DONE.
- DONE: lasts one cycle. o_done=1, o_valid=0, o_busy=1; then back to IDLE.
- Back-to-back operands: the next i_start can be accepted in the cycle after DONE. Minimum period per operand is NDIG+2 cycles with i_ready held high.
- i_start while o_busy=1 is ignored, with no effect on state or data.
- i_ready while o_valid=0 is ignored.
- NDIG=1 (RADIX_BITS=DW): a single digit with o_idx=0 and o_last=1.
- count never exceeds NDIG-1 and never wraps.

Optional Feature:
Macro: MULT_DIGIT_EARLY_TERM_EN
- Defined: o_last also asserts when (shift_reg >> RADIX_BITS)==0, i.e. all remaining digits are zero. Handshaking that digit ends the sequence (DONE next cycle). An operand of 0 yields exactly one digit, 0, with o_last=1. o_idx still reports the true index.
- Undefined: always exactly NDIG digits per operand; zero digits are emitted.

Test Plan:
1. DW=8, RADIX_BITS=1, i_data=0xA5, i_ready=1 -> digits 1,0,1,0,0,1,0,1 at o_idx 0..7; o_last only at idx 7; o_done pulse on the next cycle; o_busy low one cycle later.
2. DW=8, RADIX_BITS=2, i_data=0xB4 -> digits 0,1,3,2; o_last at idx 3. DW=7, RADIX_BITS=2, i_data=0x7F -> digits 3,3,3,1 (zero-padded top digit).
3. Backpressure: test 1 with i_ready=0 for 3 cycles at idx 2 -> o_digit=1, o_idx=2, o_valid=1 held stable for all 3 cycles; sequence resumes unchanged; total digit count is 8.
4. i_start with i_data=0xFF pulsed at idx 4 of the 0xA5 run -> ignored; remaining digits 0,1,0,1. A new start the cycle after o_done is accepted.
5. i_rst=0 asserted at idx 3 -> outputs 0 asynchronously; no o_done; after release o_busy=0 until a new i_start.
6. i_data=0x05, RADIX_BITS=1: with MULT_DIGIT_EARLY_TERM_EN -> digits 1,0,1 and o_last at idx 2. Without the macro -> 8 digits and o_last at idx 7. With i_data=0 and the macro -> one digit, 0, with o_last=1.
